// File: rtl/cp0_regfile.sv
// CP0 architectural register file: commits MTC0 writes, runs the Count/Compare
// timer, records exception entry/ERET and produces the registered interrupt request.
package cp0_regfile_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0] creg_addr_t;

  localparam creg_addr_t CREG_BADVADDR = 5'd8;
  localparam creg_addr_t CREG_COUNT    = 5'd9;
  localparam creg_addr_t CREG_COMPARE  = 5'd11;
  localparam creg_addr_t CREG_STATUS   = 5'd12;
  localparam creg_addr_t CREG_CAUSE    = 5'd13;
  localparam creg_addr_t CREG_EPC      = 5'd14;
  localparam creg_addr_t CREG_ERROREPC = 5'd30;

  typedef struct packed {
    logic [XLEN-1:0] badvaddr;
    logic [XLEN-1:0] count;
    logic [XLEN-1:0] compare;
    logic [XLEN-1:0] status;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] errorepc;
  } cp0_t;

endpackage

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  creg_addr_t       wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic             exc_bd,
  input  logic             exc_badva_valid,
  input  logic [XLEN-1:0]  exc_badva,
  input  logic             eret,
  input  logic [5:0]       ext_int,
  output cp0_t             cp0,
  output logic             int_pending
);

  // Cause bit positions
  localparam int unsigned CAUSE_BD  = 31;
  localparam int unsigned CAUSE_TI  = 30;
  localparam int unsigned STAT_EXL  = 1;
  localparam int unsigned STAT_IE   = 0;

  // Only the software interrupt bits IP[1:0] are writable; the rest of Cause
  // is either hardware-owned or unimplemented (reads zero).
  localparam logic [XLEN-1:0] CAUSE_SW_MASK = 32'h0000_0300;

  cp0_t cp0_nxt;
  logic tick_phase;
  logic tick_phase_nxt;
  logic tick_last;
  logic mtc0;
  logic int_nxt;

  always_comb begin
    cp0_nxt        = cp0;
    mtc0           = wr_en & ~exc_valid & ~eret;
    tick_last      = (COUNT_DIV == 32'd1) || tick_phase;
    tick_phase_nxt = ~tick_last;

    if (tick_last) begin
      cp0_nxt.count = cp0.count + 32'd1;
    end

    // Software writes; Count write also restarts the divider phase
    if (mtc0) begin
      case (wr_addr)
        CREG_BADVADDR: cp0_nxt.badvaddr = wr_data;
        CREG_COUNT: begin
          cp0_nxt.count  = wr_data;
          tick_phase_nxt = 1'b0;
        end
        CREG_COMPARE:  cp0_nxt.compare  = wr_data;
        CREG_STATUS:   cp0_nxt.status   = wr_data;
        CREG_CAUSE:    cp0_nxt.cause    = (cp0.cause & ~CAUSE_SW_MASK) | (wr_data & CAUSE_SW_MASK);
        CREG_EPC:      cp0_nxt.epc      = wr_data;
        CREG_ERROREPC: cp0_nxt.errorepc = wr_data;
        default: ;
      endcase
    end

    // Timer interrupt: a Compare write clears TI even if a match happens now
    if (mtc0 && (wr_addr == CREG_COMPARE)) begin
      cp0_nxt.cause[CAUSE_TI] = 1'b0;
    end else if (cp0.count == cp0.compare) begin
      cp0_nxt.cause[CAUSE_TI] = 1'b1;
    end

    cp0_nxt.cause[15:10] = {ext_int[5] | cp0.cause[CAUSE_TI], ext_int[4:0]};

    if (exc_valid) begin
      if (!cp0.status[STAT_EXL]) begin
        cp0_nxt.epc             = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        cp0_nxt.cause[CAUSE_BD] = exc_bd;
      end
      cp0_nxt.status[STAT_EXL] = 1'b1;
      cp0_nxt.cause[6:2]       = exc_code;
      if (exc_badva_valid) begin
        cp0_nxt.badvaddr = exc_badva;
      end
    end else if (eret) begin
      cp0_nxt.status[STAT_EXL] = 1'b0;
    end

    int_nxt = ~exc_valid & cp0.status[STAT_IE] & ~cp0.status[STAT_EXL] &
              (|(cp0.cause[15:8] & cp0.status[15:8]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cp0          <= '0;
      cp0.status   <= STATUS_RST;
      tick_phase   <= 1'b0;
      int_pending  <= 1'b0;
    end else begin
      cp0          <= cp0_nxt;
      tick_phase   <= tick_phase_nxt;
      int_pending  <= int_nxt;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: timer, exceptions, ERET, priorities, interrupts, reset.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  creg_addr_t  wr_addr;
  logic [31:0] wr_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badva_valid;
  logic [31:0] exc_badva;
  logic        eret;
  logic [5:0]  ext_int;
  cp0_t        cp0;
  logic        int_pending;

  int checks = 0;
  int failures = 0;

  cp0_regfile #(.COUNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva_valid(exc_badva_valid), .exc_badva(exc_badva),
    .eret(eret), .ext_int(ext_int),
    .cp0(cp0), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    wr_en = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_badva_valid = 1'b0;
  endtask

  task automatic mtc0(input creg_addr_t a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic bv, input logic [31:0] va);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badva_valid = bv; exc_badva = va;
    step();
    clear_strobes();
  endtask

  initial begin
    reset = 1'b1; wr_addr = '0; wr_data = '0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badva = '0; ext_int = '0;
    clear_strobes();
    step(); step();
    reset = 1'b0;

    // Reset values
    chk("rst_status", cp0.status, 32'h0040_0000);
    chk("rst_cause", cp0.cause, 32'h0);
    chk("rst_epc", cp0.epc, 32'h0);
    chk("rst_count", cp0.count, 32'h0);
    chk("rst_compare", cp0.compare, 32'h0);
    chk("rst_int", 32'(int_pending), 32'h0);

    // Timer: Compare=5, Count=0, Count advances every second cycle
    mtc0(CREG_COMPARE, 32'd5);
    mtc0(CREG_COUNT, 32'd0);
    repeat (10) step();
    chk("count_at_10", cp0.count, 32'd5);
    chk("ti_before", 32'(cp0.cause[30]), 32'h0);
    step();
    chk("ti_set", 32'(cp0.cause[30]), 32'h1);
    step();
    chk("ip7_set", 32'(cp0.cause[15]), 32'h1);
    chk("count_6", cp0.count, 32'd6);
    mtc0(CREG_COMPARE, 32'd20);
    chk("ti_clear", 32'(cp0.cause[30]), 32'h0);
    chk("compare_20", cp0.compare, 32'd20);
    step();
    chk("ip7_clear", 32'(cp0.cause[15]), 32'h0);

    // Exception in delay slot with BadVAddr
    raise_exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h0000_0003);
    chk("exc_epc", cp0.epc, 32'hBFC0_0100);
    chk("exc_bd", 32'(cp0.cause[31]), 32'h1);
    chk("exc_status", cp0.status, 32'h0040_0002);
    chk("exc_code", 32'(cp0.cause[6:2]), 32'd4);
    chk("exc_badva", cp0.badvaddr, 32'h0000_0003);

    // Nested exception while EXL=1
    raise_exc(5'd5, 32'h0000_1000, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("nest_epc", cp0.epc, 32'hBFC0_0100);
    chk("nest_bd", 32'(cp0.cause[31]), 32'h1);
    chk("nest_code", 32'(cp0.cause[6:2]), 32'd5);
    chk("nest_badva", cp0.badvaddr, 32'h0000_0003);

    eret = 1'b1; step(); clear_strobes();
    chk("eret_status", cp0.status, 32'h0040_0000);
    chk("eret_epc", cp0.epc, 32'hBFC0_0100);

    // exc + eret + MTC0 Status together: exception only
    wr_en = 1'b1; wr_addr = CREG_STATUS; wr_data = 32'h0; eret = 1'b1;
    raise_exc(5'd8, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
    chk("prio_status", cp0.status, 32'h0040_0002);
    chk("prio_epc", cp0.epc, 32'h0000_2000);
    chk("prio_bd", 32'(cp0.cause[31]), 32'h0);
    chk("prio_code", 32'(cp0.cause[6:2]), 32'd8);

    // eret beats MTC0 EPC
    eret = 1'b1; wr_en = 1'b1; wr_addr = CREG_EPC; wr_data = 32'h0000_1234;
    step(); clear_strobes();
    chk("eret_wr_status", cp0.status, 32'h0040_0000);
    chk("eret_wr_epc", cp0.epc, 32'h0000_2000);

    // Interrupt path: IE + IM2 with ext_int[0]
    ext_int = 6'b000001;
    mtc0(CREG_STATUS, 32'h0000_0401);
    chk("int_lag0", 32'(int_pending), 32'h0);
    chk("ip2", 32'(cp0.cause[10]), 32'h1);
    step();
    chk("int_on", 32'(int_pending), 32'h1);
    mtc0(CREG_STATUS, 32'h0000_0403);
    chk("int_lag1", 32'(int_pending), 32'h1);
    step();
    chk("int_exl_off", 32'(int_pending), 32'h0);

    mtc0(CREG_STATUS, 32'h0000_0401);
    step();
    chk("int_on2", 32'(int_pending), 32'h1);
    raise_exc(5'd0, 32'h0000_3000, 1'b0, 1'b0, 32'h0);
    chk("int_exc_force", 32'(int_pending), 32'h0);
    chk("int_exc_status", cp0.status, 32'h0000_0403);
    step();
    chk("int_exc_after", 32'(int_pending), 32'h0);
    eret = 1'b1; step(); clear_strobes();
    ext_int = 6'b0;

    // Unmapped address ignored; ErrorEPC writable
    mtc0(5'd10, 32'hFFFF_FFFF);
    chk("unmap_status", cp0.status, 32'h0000_0401);
    chk("unmap_epc", cp0.epc, 32'h0000_3000);
    chk("unmap_compare", cp0.compare, 32'd20);
    mtc0(CREG_ERROREPC, 32'h1357_9BDF);
    chk("errorepc", cp0.errorepc, 32'h1357_9BDF);

    // Count wrap
    mtc0(CREG_COUNT, 32'hFFFF_FFFF);
    chk("wrap_w", cp0.count, 32'hFFFF_FFFF);
    step();
    chk("wrap_1", cp0.count, 32'hFFFF_FFFF);
    step();
    chk("wrap_2", cp0.count, 32'h0);

    // Cause write: only IP[1:0] software bits take
    mtc0(CREG_CAUSE, 32'hFFFF_FFFF);
    chk("cause_sw", cp0.cause & 32'h3FFF_0383, 32'h0000_0300);

    // Reset mid-operation discards pending strobes
    reset = 1'b1; wr_en = 1'b1; wr_addr = CREG_STATUS; wr_data = 32'hFFFF_FFFF; exc_valid = 1'b1;
    step();
    reset = 1'b0; clear_strobes();
    chk("rst2_status", cp0.status, 32'h0040_0000);
    chk("rst2_cause", cp0.cause, 32'h0);
    chk("rst2_epc", cp0.epc, 32'h0);
    chk("rst2_count", cp0.count, 32'h0);
    chk("rst2_errorepc", cp0.errorepc, 32'h0);
    chk("rst2_int", 32'(int_pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
